// File: rtl/cache_mem_responder.sv
// cache_mem_responder: turns 128-bit cache line requests into four 32-bit word-bus beats
// and returns assembled read lines; writes are posted.
package cache_mem_responder_pkg;
    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;
    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;
endpackage

module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  mem_req_type  mem_req_i,
    output mem_data_type mem_data_o,
    output logic         bus_valid_o,
    output logic         bus_we_o,
    output logic [31:0]  bus_addr_o,
    output logic [31:0]  bus_wdata_o,
    input  logic         bus_ready_i,
    input  logic [31:0]  bus_rdata_i,
    output logic         err_o,
    output logic         idle_o
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
    state_t       state, state_n;
    logic [27:0]  line_addr;
    logic [1:0]   beat;
    logic [127:0] wr_data, line;
    logic [31:0]  timer;
    logic         err, busy, beat_done, stall, timeout, accept;
    logic         unused_addr_bits;
    assign unused_addr_bits = ^mem_req_i.addr[3:0];
    always_comb begin
        busy      = state == WRITE || state == READ;
        beat_done = busy && bus_ready_i;
        stall     = busy && !bus_ready_i;
        timeout   = stall && TIMEOUT_CYCLES != 0 && timer + 32'd1 == TIMEOUT_CYCLES;
        accept    = state == IDLE && mem_req_i.valid;
        state_n   = state;
        case (state)
            IDLE:  state_n = !mem_req_i.valid ? IDLE : mem_req_i.rw ? WRITE : READ;
            WRITE: state_n = timeout || (beat_done && beat == 2'd3) ? IDLE : WRITE;
            READ:  state_n = timeout || (beat_done && beat == 2'd3) ? RESP : READ;
            RESP:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            line_addr <= '0;
            beat      <= '0;
            wr_data   <= '0;
            line      <= '0;
            timer     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                line_addr <= mem_req_i.addr[31:4];
                beat      <= '0;
                timer     <= '0;
                // a fresh read starts from a zeroed line so aborted words read back as 0
                if (mem_req_i.rw) wr_data <= mem_req_i.data;
                else line <= '0;
            end
            if (beat_done) begin
                beat  <= beat + 2'd1;
                timer <= '0;
            end else if (stall) begin
                timer <= timer + 32'd1;
            end
            if (beat_done && state == READ) line[{beat, 5'd0} +: 32] <= bus_rdata_i;
            if (timeout) err <= 1'b1;
        end
    end
    assign bus_valid_o      = busy;
    assign bus_we_o         = state == WRITE;
    assign bus_addr_o       = {line_addr, beat, 2'b00};
    assign bus_wdata_o      = wr_data[{beat, 5'd0} +: 32];
    assign mem_data_o.data  = line;
    assign mem_data_o.ready = state == RESP;
    assign err_o            = err;
    assign idle_o           = state == IDLE;
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: directed checks of line read, posted write-back, stalls, timeout and reset.
module tb_cache_mem_responder;
    import cache_mem_responder_pkg::*;
    logic         clk_i = 1'b0;
    logic         rst_ni;
    mem_req_type  req;
    mem_data_type rsp;
    logic         bus_valid_o, bus_we_o, bus_ready_i, err_o, idle_o;
    logic [31:0]  bus_addr_o, bus_wdata_o, bus_rdata_i;
    int           tests = 0, fails = 0, wr_beats = 0, wb;

    cache_mem_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem_req_i(req), .mem_data_o(rsp),
        .bus_valid_o(bus_valid_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i),
        .err_o(err_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;
    assign bus_rdata_i = 32'hA000_0000 + {2'b00, bus_addr_o[31:2]};
    always @(posedge clk_i) if (bus_valid_o && bus_we_o && bus_ready_i) wr_beats <= wr_beats + 1;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        bus_ready_i = 1'b1;
        req = '0;
        tick;
        tick;
        check("rst_idle", idle_o, 1);
        check("rst_valid", bus_valid_o, 0);
        check("rst_we", bus_we_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_wdata", bus_wdata_o, 0);
        check("rst_rsp", rsp, 0);
        check("rst_err", err_o, 0);
        rst_ni = 1'b1;
        tick;

        req = '{addr: 32'h0000_1234, data: '0, rw: 1'b0, valid: 1'b1};
        tick;
        for (int i = 0; i < 4; i++) begin
            check("zw_valid", bus_valid_o, 1);
            check("zw_we", bus_we_o, 0);
            check("zw_addr", bus_addr_o, 32'h1230 + 32'(4 * i));
            check("zw_noready", rsp.ready, 0);
            tick;
        end
        check("zw_ready", rsp.ready, 1);
        check("zw_data", rsp.data, 128'hA000048F_A000048E_A000048D_A000048C);
        check("zw_resp_novalid", bus_valid_o, 0);
        req.valid = 1'b0;
        tick;
        check("zw_ready_once", rsp.ready, 0);
        check("zw_idle", idle_o, 1);

        wb = wr_beats;
        req = '{addr: 32'h0000_2000, data: 128'h4444_3333_2222_1111, rw: 1'b1, valid: 1'b1};
        tick;
        check("wb_b0_we", bus_we_o, 1);
        check("wb_b0_addr", bus_addr_o, 32'h2000);
        check("wb_b0_wdata", bus_wdata_o, 32'h2222_1111);
        tick;
        req = '{addr: 32'h0000_5000, data: '0, rw: 1'b0, valid: 1'b1};
        check("wb_b1_addr", bus_addr_o, 32'h2004);
        check("wb_b1_wdata", bus_wdata_o, 32'h4444_3333);
        tick;
        check("wb_b2_wdata", bus_wdata_o, 32'h0);
        tick;
        check("wb_b3_addr", bus_addr_o, 32'h200C);
        check("wb_b3_we", bus_we_o, 1);
        tick;
        check("wb_drained_idle", idle_o, 1);
        check("wb_drained_novalid", bus_valid_o, 0);
        tick;
        check("fill_b0_we", bus_we_o, 0);
        check("fill_b0_addr", bus_addr_o, 32'h5000);
        tick;
        tick;
        tick;
        check("fill_b3_addr", bus_addr_o, 32'h500C);
        check("fill_b3_noready", rsp.ready, 0);
        tick;
        check("fill_ready_t10", rsp.ready, 1);
        check("fill_data", rsp.data, 128'hA0001403_A0001402_A0001401_A0001400);
        check("wb_beat_count", wr_beats - wb, 4);
        req.valid = 1'b0;
        tick;
        check("fill_idle", idle_o, 1);

        req = '{addr: 32'h0000_3000, data: '0, rw: 1'b0, valid: 1'b1};
        tick;
        check("ws_b0_addr", bus_addr_o, 32'h3000);
        tick;
        tick;
        bus_ready_i = 1'b0;
        check("ws_b2_addr", bus_addr_o, 32'h3008);
        for (int i = 0; i < 2; i++) begin
            tick;
            check("ws_stall_valid", bus_valid_o, 1);
            check("ws_stall_addr", bus_addr_o, 32'h3008);
        end
        tick;
        bus_ready_i = 1'b1;
        check("ws_stall_end_addr", bus_addr_o, 32'h3008);
        tick;
        check("ws_b3_addr", bus_addr_o, 32'h300C);
        check("ws_b3_noready", rsp.ready, 0);
        tick;
        check("ws_ready", rsp.ready, 1);
        check("ws_data", rsp.data, 128'hA0000C03_A0000C02_A0000C01_A0000C00);
        req.valid = 1'b0;
        tick;

        req = '{addr: 32'h0000_4000, data: '0, rw: 1'b0, valid: 1'b1};
        bus_ready_i = 1'b0;
        tick;
        for (int i = 0; i < 7; i++) tick;
        check("to_err_pre", err_o, 0);
        check("to_valid_pre", bus_valid_o, 1);
        tick;
        check("to_err", err_o, 1);
        check("to_ready", rsp.ready, 1);
        check("to_data", rsp.data, 128'h0);
        check("to_resp_novalid", bus_valid_o, 0);
        req.valid = 1'b0;
        bus_ready_i = 1'b1;
        tick;
        tick;
        check("to_err_sticky", err_o, 1);
        check("to_idle", idle_o, 1);

        req = '{addr: 32'h0000_1234, data: '0, rw: 1'b0, valid: 1'b1};
        tick;
        tick;
        tick;
        check("rm_b2_addr", bus_addr_o, 32'h1238);
        rst_ni = 1'b0;
        tick;
        check("rm_novalid", bus_valid_o, 0);
        check("rm_idle", idle_o, 1);
        check("rm_noready", rsp.ready, 0);
        check("rm_err_clr", err_o, 0);
        rst_ni = 1'b1;
        req = '{addr: 32'h0000_6000, data: '0, rw: 1'b0, valid: 1'b1};
        tick;
        check("rm_fresh_addr", bus_addr_o, 32'h6000);
        for (int i = 0; i < 4; i++) tick;
        check("rm_fresh_ready", rsp.ready, 1);
        check("rm_fresh_data", rsp.data, 128'hA0001803_A0001802_A0001801_A0001800);
        req.valid = 1'b0;
        tick;
        check("rm_fresh_idle", idle_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
